// File: rtl/dqpsk_tx_framer_if.sv
// dqpsk_tx_framer_if
// Handshake and status bundle between a frame source and the DQPSK transmit framer.
//   start       frame request pulse (source -> framer)
//   frame_len   payload byte count, captured with start
//   byte_data   payload byte
//   byte_valid  byte_data valid
//   byte_ready  framer accepts byte_data this cycle
//   data_serial current serial bit, held between strobes
//   bit_strobe  one-cycle pulse, data_serial is new this cycle
//   i_phase     1 = current bit is the I bit of a dibit, 0 = Q bit
//   busy        frame in progress
//   done        one-cycle end-of-frame pulse
//   underrun    sticky payload-starvation flag
// The master modport is the frame source; the slave modport is the framer.
interface dqpsk_tx_framer_if #(
    parameter int unsigned LEN_W = 8
) ();
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             byte_ready;
    logic             data_serial;
    logic             bit_strobe;
    logic             i_phase;
    logic             busy;
    logic             done;
    logic             underrun;

    modport master (
        output start, frame_len, byte_data, byte_valid,
        input  byte_ready, data_serial, bit_strobe, i_phase, busy, done, underrun
    );

    modport slave (
        input  start, frame_len, byte_data, byte_valid,
        output byte_ready, data_serial, bit_strobe, i_phase, busy, done, underrun
    );
endinterface

// File: rtl/dqpsk_tx_framer.sv
// dqpsk_tx_framer
// Transmit-side frame sequencer for the DQPSK modulator chain. Emits a serial frame of
// preamble (1010...), sync word (MSB first), payload bytes (MSB first) and zero tail, one
// bit per bit_strobe, tagging each bit as the I or Q slot of a dibit.
// Ports:
//   clk   system clock
//   rstn  asynchronous active-low reset
//   bus   dqpsk_tx_framer_if.slave: start/frame_len request, byte_data/byte_valid/byte_ready
//         payload handshake, data_serial/bit_strobe/i_phase bit stream, busy/done/underrun
// Optional feature: define DQPSK_TX_SCRAMBLE_EN to XOR payload bits with a 7-bit LFSR
// (x^7+x^4+1, seeded 7'h7F on start, advanced once per payload strobe).
module dqpsk_tx_framer #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned PREAMBLE_LEN = 16,
    parameter logic [31:0] SYNC_WORD    = 32'h0000_D391,
    parameter int unsigned SYNC_LEN     = 16,
    parameter int unsigned TAIL_LEN     = 4,
    parameter int unsigned LEN_W        = 8
) (
    input  logic               clk,
    input  logic               rstn,
    dqpsk_tx_framer_if.slave   bus
);
    localparam int unsigned MaxA   = (PREAMBLE_LEN > SYNC_LEN) ? PREAMBLE_LEN : SYNC_LEN;
    localparam int unsigned MaxB   = (MaxA > TAIL_LEN) ? MaxA : TAIL_LEN;
    localparam int unsigned MaxSec = (MaxB > 8) ? MaxB : 8;
    localparam int unsigned CntW   = $clog2(MaxSec);
    localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CntW-1:0] PreLast  = CntW'(PREAMBLE_LEN - 1);
    localparam logic [CntW-1:0] SyncLast = CntW'(SYNC_LEN - 1);
    localparam logic [CntW-1:0] TailLast = CntW'(TAIL_LEN - 1);
    localparam logic [CntW-1:0] ByteLast = CntW'(7);
    localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);

    typedef enum logic [2:0] {StIdle, StPreamble, StSync, StPayload, StTail} state_e;

    state_e           state_q, state_d;
    logic [DivW-1:0]  div_q, div_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;   // bytes moved into the shift register
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic             data_q, data_d;
    logic             iq_q, iq_d;               // i_phase of the most recent strobe
    logic             done_q, done_d;
    logic             underrun_q, underrun_d;
`ifdef DQPSK_TX_SCRAMBLE_EN
    logic [6:0]       lfsr_q, lfsr_d;
`endif

    logic       busy, strobe, accept, ready, xfer, load_byte, cur_bit;
    logic [4:0] sync_idx;

    assign busy     = (state_q != StIdle);
    assign strobe   = busy && (div_q == '0);
    // The cycle carrying done is still IDLE, but a start there must not be taken.
    assign accept   = (state_q == StIdle) && bus.start && !done_q;
    // Prefetch only while a payload byte is still owed to the shift register.
    assign ready    = busy && !hold_vld_q && ((state_q == StSync) || (state_q == StPayload))
                      && (byte_cnt_q < len_q);
    assign xfer     = bus.byte_valid && ready;
    assign sync_idx = 5'(SYNC_LEN - 1) - 5'(bit_cnt_q);

    always_comb begin
        cur_bit = 1'b0;
        unique case (state_q)
            StPreamble: cur_bit = ~bit_cnt_q[0];
            StSync:     cur_bit = SYNC_WORD[sync_idx];
`ifdef DQPSK_TX_SCRAMBLE_EN
            StPayload:  cur_bit = shift_q[7] ^ lfsr_q[6];
`else
            StPayload:  cur_bit = shift_q[7];
`endif
            default:    cur_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        data_d     = data_q;
        iq_d       = iq_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        load_byte  = 1'b0;
`ifdef DQPSK_TX_SCRAMBLE_EN
        lfsr_d     = lfsr_q;
`endif

        if (accept) begin
            state_d    = StPreamble;
            len_d      = bus.frame_len;
            underrun_d = 1'b0;
            div_d      = '0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            hold_vld_d = 1'b0;
            data_d     = 1'b0;
            iq_d       = 1'b0;
`ifdef DQPSK_TX_SCRAMBLE_EN
            lfsr_d     = 7'h7F;
`endif
        end

        if (busy) begin
            div_d = (div_q == DivLast) ? '0 : div_q + 1'b1;
        end

        if (xfer) begin
            hold_d     = bus.byte_data;
            hold_vld_d = 1'b1;
        end

        if (strobe) begin
            data_d    = cur_bit;
            iq_d      = ~iq_q;
            bit_cnt_d = bit_cnt_q + 1'b1;
            unique case (state_q)
                StPreamble: begin
                    if (bit_cnt_q == PreLast) begin
                        state_d   = StSync;
                        bit_cnt_d = '0;
                    end
                end
                StSync: begin
                    if (bit_cnt_q == SyncLast) begin
                        bit_cnt_d = '0;
                        if (len_q == '0) begin
                            state_d = StTail;
                        end else begin
                            state_d   = StPayload;
                            load_byte = 1'b1;
                        end
                    end
                end
                StPayload: begin
                    shift_d = {shift_q[6:0], 1'b0};
`ifdef DQPSK_TX_SCRAMBLE_EN
                    lfsr_d  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[3]};
`endif
                    if (bit_cnt_q == ByteLast) begin
                        bit_cnt_d = '0;
                        if (byte_cnt_q == len_q) begin
                            state_d = StTail;
                        end else begin
                            load_byte = 1'b1;
                        end
                    end
                end
                StTail: begin
                    if (bit_cnt_q == TailLast) begin
                        state_d   = StIdle;
                        done_d    = 1'b1;
                        data_d    = 1'b0;
                        iq_d      = 1'b0;
                        bit_cnt_d = '0;
                        div_d     = '0;
                    end
                end
                default: ;
            endcase
        end

        // Byte boundary: holding register, else a same-cycle transfer, else a zero slot.
        if (load_byte) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (hold_vld_q) begin
                shift_d    = hold_q;
                hold_vld_d = 1'b0;
            end else if (xfer) begin
                shift_d    = bus.byte_data;
                hold_vld_d = 1'b0;
            end else begin
                shift_d    = 8'h00;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            data_q     <= 1'b0;
            iq_q       <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            data_q     <= data_d;
            iq_q       <= iq_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

`ifdef DQPSK_TX_SCRAMBLE_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    assign bus.byte_ready  = ready;
    assign bus.bit_strobe  = strobe;
    assign bus.data_serial = strobe ? cur_bit : data_q;
    assign bus.i_phase     = strobe ? ~iq_q : iq_q;
    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.underrun    = underrun_q;
endmodule
